mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester (IF) and the data requester (D, for lw/sw).
- Sits between the control/datapath and the unified memory.
- Serialises accesses, applies data-first priority with an anti-starvation guard, and tracks read latency.
- Routes each returned read word to the requester that issued it.

Parameters:
- ADDR_W, 32, address width for both requester ports and the memory port.
- DATA_W, 32, data word width.
- RD_LAT, 1, memory read latency in cycles; must be >=1 (elaboration error otherwise).
- MAX_D_STREAK, 2, maximum consecutive D grants while if_req is pending before IF is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only).
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only ever 1 when mem_en=1.
- mem_addr  out  ADDR_W  memory address; 0 when mem_en=0.
- mem_wdata  out  DATA_W  memory write data; 0 unless mem_we=1.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the issue cycle.
- busy  out  1  a read is in flight.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, streak=0, lat_cnt=0, owner=IF. All gnt/rvalid/mem_en/mem_we/busy=0; rdata registers=0.
- Any in-flight read is discarded: no rvalid after reset release.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read issued, lat_cnt counting down from RD_LAT.
  - RESP: data captured, rvalid asserted this cycle.
- Issue is legal in IDLE and RESP only.
- Issue is combinational in the same cycle: gnt, mem_en, mem_we, mem_addr and mem_wdata are driven from the winning requester's inputs.
- Arbitration when both request:
  - D wins unless streak==MAX_D_STREAK; then IF wins.
  - streak increments on each D grant while if_req=1, and clears on any IF grant or when if_req=0.
  - A sole requester always wins.
  - At most one gnt per cycle.
- Store granted (d_we=1): mem_we=1 for that cycle, no rvalid, state stays or returns IDLE.
  - Back-to-back stores may be granted every cycle.
- Load/fetch granted in cycle T:
  - Record owner; go to RD_WAIT with lat_cnt=RD_LAT-1.
  - Data is captured at the end of cycle T+RD_LAT.
  - In cycle T+RD_LAT+1: state=RESP, the owner's rvalid=1 and its rdata=captured word.
  - The other requester's rvalid stays 0 and its rdata holds its previous value.
- Latency: read gnt to rvalid = RD_LAT+1 cycles. Sustained read throughput = one per RD_LAT+1 cycles.
- From RESP: a new grant goes to RD_WAIT (read) or IDLE (store). No request goes to IDLE.
- busy=1 in RD_WAIT; busy=0 in IDLE and RESP.
- In RD_WAIT no gnt is issued; requests stay pending, and the streak is unchanged.
- A requester that drops req before gnt gets no access. Changing inputs while req=1 and gnt=0 is a protocol violation; the bench asserts on it.
- rdata registers update only on capture; they hold otherwise.

Decomposition:
- Package mem_arb_pkg:
  - owner enum OWN_IF=1'b0, OWN_D=1'b1.
  - state enum IDLE/RD_WAIT/RESP (2 bits).
  - default ADDR_W/DATA_W constants.
- No sub-module. The latency counter and streak counter stay inline; each is under 15 lines.

Test Plan:
- reset=0 with if_req=1, then release -> all outputs 0 during reset. First cycle after release: if_gnt=1, mem_en=1, mem_addr=if_addr=0x10. With RD_LAT=1, if_rvalid=1 two cycles later carrying mem_rdata.
- Simultaneous if_req (0x20) and d_req load (0x80), MAX_D_STREAK=2, D held requesting -> grant order D, D, IF, D, D, IF. Each rvalid pulses on the correct port only, with the matching data.
- Three back-to-back d_we=1 stores to 0x0/0x4/0x8 with data 0xA/0xB/0xC -> d_gnt=1 and mem_we=1 on three consecutive cycles; no rvalid; busy stays 0.
- RD_LAT=3, single fetch -> busy=1 for 3 cycles; if_rvalid 4 cycles after gnt. A d_req raised during the wait is granted only in the RESP cycle.
- Reset asserted mid-RD_WAIT -> busy=0 immediately; no if_rvalid/d_rvalid after release; if_rdata/d_rdata=0.
- d_req load with if_req=0 for 5 reads -> streak never forces IF; every d_gnt granted in IDLE/RESP; d_rdata matches the memory model each time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the IF/D memory arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
// Data-first priority with a streak guard for fetch; reads return to the issuing requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(RD_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    generate
        if (RD_LAT < 1) begin : g_bad_rd_lat
            $error("mem_arbiter: RD_LAT must be >= 1");
        end
    endgenerate

    state_e               r_state;
    state_e               w_state_nxt;
    owner_e               r_owner;
    logic [CNT_W-1:0]     r_lat_cnt;
    logic [STREAK_W-1:0]  r_streak;
    logic [DATA_W-1:0]    r_if_rdata;
    logic [DATA_W-1:0]    r_d_rdata;
    logic                 w_can_issue;
    logic                 w_if_win;
    logic                 w_if_gnt;
    logic                 w_d_gnt;
    logic                 w_capture;

    // Gating with reset keeps every strobe low while reset is held.
    assign w_can_issue = reset && (r_state != RD_WAIT);
    assign w_if_win    = if_req && (!d_req || (r_streak == STREAK_MAX));
    assign w_if_gnt    = w_can_issue && w_if_win;
    assign w_d_gnt     = w_can_issue && d_req && !w_if_win;
    assign w_capture   = (r_state == RD_WAIT) && (r_lat_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (w_if_gnt || (w_d_gnt && !d_we)) begin
                    w_state_nxt = RD_WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (w_capture) begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lat_cnt <= '0;
        end else if ((r_state != RD_WAIT) && (w_state_nxt == RD_WAIT)) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == RD_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
        end
    end

    // Streak is frozen while a read is outstanding since no arbitration happens then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (r_state != RD_WAIT) begin
            if (w_if_gnt || !if_req) begin
                r_streak <= '0;
            end else if (w_d_gnt) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_IF;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_gnt) begin
                r_owner <= OWN_IF;
            end else if (w_d_gnt && !d_we) begin
                r_owner <= OWN_D;
            end
            if (w_capture && (r_owner == OWN_IF)) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_capture && (r_owner == OWN_D)) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_if_gnt || w_d_gnt;
    assign mem_we    = w_d_gnt && d_we;
    assign mem_addr  = w_if_gnt ? if_addr : (w_d_gnt ? d_addr : '0);
    assign mem_wdata = (w_d_gnt && d_we) ? d_wdata : '0;
    assign if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state == RD_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter (RD_LAT=1 and RD_LAT=3)
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        t3_if_req, t3_if_gnt, t3_if_rvalid;
    logic [31:0] t3_if_addr, t3_if_rdata;
    logic        t3_d_req, t3_d_we, t3_d_gnt, t3_d_rvalid;
    logic [31:0] t3_d_addr, t3_d_wdata, t3_d_rdata;
    logic        t3_mem_en, t3_mem_we, t3_busy;
    logic [31:0] t3_mem_addr, t3_mem_wdata, t3_mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_D_STREAK(2)) u_dut (
        .clk(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_D_STREAK(2)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .if_req(t3_if_req), .if_addr(t3_if_addr), .if_gnt(t3_if_gnt),
        .if_rvalid(t3_if_rvalid), .if_rdata(t3_if_rdata),
        .d_req(t3_d_req), .d_we(t3_d_we), .d_addr(t3_d_addr), .d_wdata(t3_d_wdata),
        .d_gnt(t3_d_gnt), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata),
        .mem_en(t3_mem_en), .mem_we(t3_mem_we), .mem_addr(t3_mem_addr),
        .mem_wdata(t3_mem_wdata), .mem_rdata(t3_mem_rdata), .busy(t3_busy)
    );

    // Memory model: unwritten words read as 0x1000_0000 | byte address.
    logic [31:0] wmem [256];
    bit   [255:0] wvalid;
    logic [31:0] rd1, p1, p2, p3;

    function automatic logic [31:0] mem_val(input logic [7:0] idx);
        return wvalid[idx] ? wmem[idx] : (32'h1000_0000 | {22'd0, idx, 2'b00});
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr[9:2]]   <= mem_wdata;
            wvalid[mem_addr[9:2]] <= 1'b1;
        end
        rd1 <= (mem_en && !mem_we) ? mem_val(mem_addr[9:2]) : 32'hDEAD_BEEF;
        p1  <= (t3_mem_en && !t3_mem_we) ? mem_val(t3_mem_addr[9:2]) : 32'hDEAD_BEEF;
        p2  <= p1;
        p3  <= p2;
    end
    assign mem_rdata    = rd1;
    assign t3_mem_rdata = p3;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requester inputs must stay put while a request waits for its grant.
    logic        pv_if_wait, pv_d_wait;
    logic [31:0] pv_if_addr, pv_d_addr, pv_d_wdata;
    logic        pv_d_we;
    always @(negedge clk) begin
        if (rst_n && if_req && pv_if_wait) chk32("proto_if_addr", if_addr, pv_if_addr);
        if (rst_n && d_req && pv_d_wait) begin
            chk32("proto_d_addr", d_addr, pv_d_addr);
            chk32("proto_d_wdata", d_wdata, pv_d_wdata);
            chk1("proto_d_we", d_we, pv_d_we);
        end
        pv_if_wait = rst_n && if_req && !if_gnt;
        pv_d_wait  = rst_n && d_req && !d_gnt;
        pv_if_addr = if_addr;
        pv_d_addr  = d_addr;
        pv_d_wdata = d_wdata;
        pv_d_we    = d_we;
    end

    typedef struct {
        logic [2:0]  in_f;    // {if_req, d_req, d_we}
        logic [31:0] ifa;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [6:0]  ex_f;    // {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid}
        logic [31:0] ex_maddr;
        logic [31:0] ex_rdata;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic [2:0] in_f, input logic [31:0] ifa, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [6:0] ex_f,
                       input logic [31:0] ex_maddr, input logic [31:0] ex_rdata);
        vec_t v;
        v.in_f = in_f; v.ifa = ifa; v.da = da; v.dwd = dwd;
        v.ex_f = ex_f; v.ex_maddr = ex_maddr; v.ex_rdata = ex_rdata;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IA = 32'h20;
    localparam logic [31:0] DA = 32'h80;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        t3_if_req = 1'b0; t3_if_addr = '0;
        t3_d_req = 1'b0; t3_d_we = 1'b0; t3_d_addr = '0; t3_d_wdata = '0;

        // Arbitration: both requesting, streak forces IF every third grant
        add(3'b110, IA, DA, 0, 7'b0110000, DA, 0);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b110, IA, DA, 0, 7'b0110001, DA, 32'h1000_0080);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b110, IA, DA, 0, 7'b1010001, IA, 32'h1000_0080);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b110, IA, DA, 0, 7'b0110010, DA, 32'h1000_0020);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b110, IA, DA, 0, 7'b0110001, DA, 32'h1000_0080);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b110, IA, DA, 0, 7'b1010001, IA, 32'h1000_0080);
        add(3'b110, IA, DA, 0, 7'b0000100, 0, 0);
        add(3'b000, 0, 0, 0, 7'b0000010, 0, 32'h1000_0020);
        add(3'b000, 0, 0, 0, 7'b0000000, 0, 0);
        // Back-to-back stores
        add(3'b011, 0, 32'h0, 32'hA, 7'b0111000, 32'h0, 0);
        add(3'b011, 0, 32'h4, 32'hB, 7'b0111000, 32'h4, 0);
        add(3'b011, 0, 32'h8, 32'hC, 7'b0111000, 32'h8, 0);
        add(3'b000, 0, 0, 0, 7'b0000000, 0, 0);
        // Five D-only loads, each next request presented during the wait
        add(3'b010, 0, 32'h0, 0, 7'b0110000, 32'h0, 0);
        add(3'b010, 0, 32'h4, 0, 7'b0000100, 0, 0);
        add(3'b010, 0, 32'h4, 0, 7'b0110001, 32'h4, 32'hA);
        add(3'b010, 0, 32'h8, 0, 7'b0000100, 0, 0);
        add(3'b010, 0, 32'h8, 0, 7'b0110001, 32'h8, 32'hB);
        add(3'b010, 0, 32'h80, 0, 7'b0000100, 0, 0);
        add(3'b010, 0, 32'h80, 0, 7'b0110001, 32'h80, 32'hC);
        add(3'b010, 0, 32'h84, 0, 7'b0000100, 0, 0);
        add(3'b010, 0, 32'h84, 0, 7'b0110001, 32'h84, 32'h1000_0080);
        add(3'b000, 0, 0, 0, 7'b0000100, 0, 0);
        add(3'b000, 0, 0, 0, 7'b0000001, 0, 32'h1000_0084);
        add(3'b000, 0, 0, 0, 7'b0000000, 0, 0);

        // Reset held with a pending fetch
        @(negedge clk);
        @(negedge clk);
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rel_if_gnt", if_gnt, 1'b1);
        chk1("rel_mem_en", mem_en, 1'b1);
        chk32("rel_mem_addr", mem_addr, 32'h10);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk1("rel_busy", busy, 1'b1);
        tick();
        @(negedge clk);
        chk1("rel_if_rvalid", if_rvalid, 1'b1);
        chk32("rel_if_rdata", if_rdata, 32'h1000_0010);
        chk1("rel_busy_resp", busy, 1'b0);
        tick();

        for (int i = 0; i < vt.size(); i++) begin
            if_req  = vt[i].in_f[2];
            d_req   = vt[i].in_f[1];
            d_we    = vt[i].in_f[0];
            if_addr = vt[i].ifa;
            d_addr  = vt[i].da;
            d_wdata = vt[i].dwd;
            @(negedge clk);
            chk1($sformatf("v%0d_if_gnt", i), if_gnt, vt[i].ex_f[6]);
            chk1($sformatf("v%0d_d_gnt", i), d_gnt, vt[i].ex_f[5]);
            chk1($sformatf("v%0d_mem_en", i), mem_en, vt[i].ex_f[4]);
            chk1($sformatf("v%0d_mem_we", i), mem_we, vt[i].ex_f[3]);
            chk1($sformatf("v%0d_busy", i), busy, vt[i].ex_f[2]);
            chk1($sformatf("v%0d_if_rvalid", i), if_rvalid, vt[i].ex_f[1]);
            chk1($sformatf("v%0d_d_rvalid", i), d_rvalid, vt[i].ex_f[0]);
            chk32($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].ex_maddr);
            chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].ex_f[3] ? vt[i].dwd : 32'h0);
            if (vt[i].ex_f[1]) chk32($sformatf("v%0d_if_rdata", i), if_rdata, vt[i].ex_rdata);
            if (vt[i].ex_f[0]) chk32($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].ex_rdata);
            tick();
        end

        // RD_LAT=3: fetch, then a load raised during the wait
        t3_if_req = 1'b1; t3_if_addr = 32'h40;
        @(negedge clk);
        chk1("l3_if_gnt", t3_if_gnt, 1'b1);
        chk32("l3_mem_addr", t3_mem_addr, 32'h40);
        for (int c = 1; c <= 3; c++) begin
            tick();
            t3_if_req = 1'b0;
            if (c == 2) begin
                t3_d_req = 1'b1; t3_d_addr = 32'h44;
            end
            @(negedge clk);
            chk1($sformatf("l3_busy_c%0d", c), t3_busy, 1'b1);
            chk1($sformatf("l3_d_gnt_c%0d", c), t3_d_gnt, 1'b0);
            chk1($sformatf("l3_if_rvalid_c%0d", c), t3_if_rvalid, 1'b0);
        end
        tick();
        @(negedge clk);
        chk1("l3_resp_busy", t3_busy, 1'b0);
        chk1("l3_resp_if_rvalid", t3_if_rvalid, 1'b1);
        chk32("l3_resp_if_rdata", t3_if_rdata, 32'h1000_0040);
        chk1("l3_resp_d_gnt", t3_d_gnt, 1'b1);
        chk32("l3_resp_mem_addr", t3_mem_addr, 32'h44);
        for (int c = 1; c <= 3; c++) begin
            tick();
            t3_d_req = 1'b0;
            @(negedge clk);
            chk1($sformatf("l3_d_busy_c%0d", c), t3_busy, 1'b1);
            chk1($sformatf("l3_d_rvalid_c%0d", c), t3_d_rvalid, 1'b0);
        end
        tick();
        @(negedge clk);
        chk1("l3_d_rvalid", t3_d_rvalid, 1'b1);
        chk32("l3_d_rdata", t3_d_rdata, 32'h1000_0044);
        chk1("l3_if_rvalid_quiet", t3_if_rvalid, 1'b0);
        chk32("l3_if_rdata_hold", t3_if_rdata, 32'h1000_0040);
        tick();

        // Reset in the middle of a read wait
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk1("mr_if_gnt", if_gnt, 1'b1);
        tick();
        if_req = 1'b0;
        chk1("mr_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mr_busy_async", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("mr_if_rvalid_c%0d", c), if_rvalid, 1'b0);
            chk1($sformatf("mr_d_rvalid_c%0d", c), d_rvalid, 1'b0);
            chk32($sformatf("mr_if_rdata_c%0d", c), if_rdata, 32'h0);
            chk32($sformatf("mr_d_rdata_c%0d", c), d_rdata, 32'h0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
